exec_muldiv_seq: RTL and testbench

//  Parametrised multi-cycle multiply/divide unit for the execute stage, next to the single-cycle ALU.

---
 rtl/muldiv_pkg.sv | 24 ++
 rtl/muldiv_step.sv | 49 ++++
 rtl/exec_muldiv_seq.sv | 165 ++++++++++++++++
 tb/tb_exec_muldiv_seq.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: opcodes, FSM states and step modes.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIX  = 2'b10
  } state_e;

  typedef enum logic {
    STEP_MUL = 1'b0,
    STEP_DIV = 1'b1
  } step_mode_e;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract for divide.
// The divide path exists only when MULDIV_DIV_EN is defined.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] partial,
  input  logic [DATA_W-1:0] operand,
  input  logic [DATA_W-1:0] shreg,
  input  step_mode_e        mode,
  output logic [DATA_W-1:0] partial_nxt,
  output logic [DATA_W-1:0] shreg_nxt
);

  logic [DATA_W:0] sum;

  // Multiply: {partial, shreg} shifts right; the multiplier LSB selects the add.
  assign sum = {1'b0, partial} + (shreg[0] ? {1'b0, operand} : {(DATA_W + 1){1'b0}});

`ifdef MULDIV_DIV_EN
  logic [DATA_W:0] shifted;
  logic [DATA_W:0] diff;
  logic            ge;
  logic            unused_diff_msb;

  // Divide: {partial, shreg} shifts left; the remainder stays below the divisor.
  assign shifted         = {partial, shreg[DATA_W-1]};
  assign ge              = shifted >= {1'b0, operand};
  assign diff            = shifted - {1'b0, operand};
  assign unused_diff_msb = diff[DATA_W];

  always_comb begin
    partial_nxt = sum[DATA_W:1];
    shreg_nxt   = {sum[0], shreg[DATA_W-1:1]};
    if (mode == STEP_DIV) begin
      partial_nxt = ge ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
      shreg_nxt   = {shreg[DATA_W-2:0], ge};
    end
  end
`else
  logic unused_mode;

  assign unused_mode = mode;
  assign partial_nxt = sum[DATA_W:1];
  assign shreg_nxt   = {sum[0], shreg[DATA_W-1:1]};
`endif

endmodule

// File: rtl/exec_muldiv_seq.sv
// Multi-cycle mult/multu/div/divu unit owning HI/LO, with mthi/mtlo and a start/busy/done handshake.
// Define MULDIV_DIV_EN to build the divider; without it DIV/DIVU are ignored and div_zero stays 0.
module exec_muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic              flush,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              div_zero
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  state_e              state_q;
  step_mode_e          mode_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   opnd_q, partial_q, shreg_q, hi_q, lo_q;
  logic                neg_lo_q, done_q, div_zero_q;
  logic [DATA_W-1:0]   step_partial, step_shreg;
  logic                signed_op, a_neg, b_neg;
  logic [DATA_W-1:0]   a_mag, b_mag;
  logic [2*DATA_W-1:0] prod, prod_fix;

  always_comb begin
    signed_op = (op == OP_MULT) || (op == OP_DIV);
    a_neg     = signed_op && a_in[DATA_W-1];
    b_neg     = signed_op && b_in[DATA_W-1];
    a_mag     = a_neg ? -a_in : a_in;
    b_mag     = b_neg ? -b_in : b_in;
    prod      = {partial_q, shreg_q};
    prod_fix  = neg_lo_q ? -prod : prod;
  end

`ifdef MULDIV_DIV_EN
  logic                neg_hi_q;
  logic [DATA_W-1:0]   quo_fix, rem_fix;

  // Quotient takes the XOR of signs, remainder takes the dividend's sign.
  assign quo_fix = neg_lo_q ? -shreg_q : shreg_q;
  assign rem_fix = neg_hi_q ? -partial_q : partial_q;
`endif

  muldiv_step #(
    .DATA_W(DATA_W)
  ) u_step (
    .partial    (partial_q),
    .operand    (opnd_q),
    .shreg      (shreg_q),
    .mode       (mode_q),
    .partial_nxt(step_partial),
    .shreg_nxt  (step_shreg)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      mode_q     <= STEP_MUL;
      cnt_q      <= '0;
      opnd_q     <= '0;
      partial_q  <= '0;
      shreg_q    <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      neg_lo_q   <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
`ifdef MULDIV_DIV_EN
      neg_hi_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start && !flush) begin
            case (op)
              OP_MULT, OP_MULTU: begin
                state_q    <= S_RUN;
                mode_q     <= STEP_MUL;
                opnd_q     <= a_mag;
                shreg_q    <= b_mag;
                partial_q  <= '0;
                neg_lo_q   <= a_neg ^ b_neg;
                cnt_q      <= CNT_W'(DATA_W);
                div_zero_q <= 1'b0;
              end
`ifdef MULDIV_DIV_EN
              OP_DIV, OP_DIVU: begin
                div_zero_q <= (b_in == '0);
                if (b_in == '0) begin
                  hi_q   <= a_in;
                  lo_q   <= '1;
                  done_q <= 1'b1;
                end else begin
                  state_q   <= S_RUN;
                  mode_q    <= STEP_DIV;
                  opnd_q    <= b_mag;
                  shreg_q   <= a_mag;
                  partial_q <= '0;
                  neg_lo_q  <= a_neg ^ b_neg;
                  neg_hi_q  <= a_neg;
                  cnt_q     <= CNT_W'(DATA_W);
                end
              end
`endif
              OP_MTHI: begin
                hi_q       <= a_in;
                done_q     <= 1'b1;
                div_zero_q <= 1'b0;
              end
              OP_MTLO: begin
                lo_q       <= a_in;
                done_q     <= 1'b1;
                div_zero_q <= 1'b0;
              end
              default: ;
            endcase
          end
        end
        S_RUN: begin
          if (flush) begin
            state_q <= S_IDLE;
          end else begin
            partial_q <= step_partial;
            shreg_q   <= step_shreg;
            cnt_q     <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_q <= S_FIX;
          end
        end
        S_FIX: begin
          state_q <= S_IDLE;
          if (!flush) begin
            done_q <= 1'b1;
`ifdef MULDIV_DIV_EN
            if (mode_q == STEP_DIV) begin
              hi_q <= rem_fix;
              lo_q <= quo_fix;
            end else
`endif
            begin
              {hi_q, lo_q} <= prod_fix;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = div_zero_q;

endmodule

// File: tb/tb_exec_muldiv_seq.sv
// Scoreboard bench for exec_muldiv_seq at DATA_W=32 and DATA_W=8.
module tb_exec_muldiv_seq;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start, flush, busy, done, dz;
  logic [2:0]  op;
  logic [31:0] a, b, hi, lo;
  logic        start8, flush8, busy8, done8, dz8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8, hi8, lo8;

  exec_muldiv_seq #(.DATA_W(32)) dut (
    .clock(clk), .reset(rst), .start(start), .op(op), .a_in(a), .b_in(b), .flush(flush),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_zero(dz)
  );

  exec_muldiv_seq #(.DATA_W(8)) dut8 (
    .clock(clk), .reset(rst), .start(start8), .op(op8), .a_in(a8), .b_in(b8), .flush(flush8),
    .busy(busy8), .done(done8), .hi(hi8), .lo(lo8), .div_zero(dz8)
  );

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  exp_t        q32[$];
  exp_t        q8[$];
  int          n_pass = 0;
  int          n_total = 0;
  logic [31:0] hi_m = '0;
  logic [31:0] lo_m = '0;
  logic [33:0] btr, dtr;
  logic [9:0]  btr8, dtr8;

  function automatic exp_t mk(input logic [31:0] h, input logic [31:0] l, input logic d);
    exp_t e;
    e.hi = h;
    e.lo = l;
    e.dz = d;
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  always @(negedge clk) begin : mon32
    exp_t e;
    if (!rst && done) begin
      if (q32.size() == 0) begin
        n_total++;
        $display("FAIL unexpected done32: hi=%h lo=%h", hi, lo);
      end else begin
        e = q32.pop_front();
        check("done32 hi", hi, e.hi);
        check("done32 lo", lo, e.lo);
        check("done32 div_zero", dz, e.dz);
      end
    end
  end

  always @(negedge clk) begin : mon8
    exp_t e;
    if (!rst && done8) begin
      if (q8.size() == 0) begin
        n_total++;
        $display("FAIL unexpected done8: hi=%h lo=%h", hi8, lo8);
      end else begin
        e = q8.pop_front();
        check("done8 hi", hi8, e.hi);
        check("done8 lo", lo8, e.lo);
        check("done8 div_zero", dz8, e.dz);
      end
    end
  end

  // Called at a negedge; returns at a negedge with the unit idle.
  task automatic run(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                     input bit exp_done, input bit fast, input exp_t e);
    int k;
    if (exp_done) begin
      q32.push_back(e);
      hi_m = e.hi;
      lo_m = e.lo;
    end
    op = o; a = av; b = bv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (fast) check("fast path busy", busy, 0);
    if (exp_done) begin
      for (k = 0; k < 100 && q32.size() != 0; k++) @(negedge clk);
      if (q32.size() != 0) begin
        n_total++;
        $display("FAIL timeout32: op=%0d pending=%0d", o, q32.size());
        q32.delete();
      end
    end else begin
      repeat (40) @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic run8(input logic [2:0] o, input logic [7:0] av, input logic [7:0] bv,
                      input exp_t e);
    int k;
    q8.push_back(e);
    op8 = o; a8 = av; b8 = bv; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    for (k = 0; k < 40 && q8.size() != 0; k++) @(negedge clk);
    if (q8.size() != 0) begin
      n_total++;
      $display("FAIL timeout8: op=%0d pending=%0d", o, q8.size());
      q8.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
    start8 = 1'b0; flush8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset hi", hi, 0);
    check("reset lo", lo, 0);
    check("reset div_zero", dz, 0);
    check("reset busy8", busy8, 0);
    @(negedge clk);

    // Latency trace; the following start lands on edge DATA_W+2.
    q32.push_back(mk(32'hFFFFFFFE, 32'h00000001, 1'b0));
    op = OP_MULTU; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; start = 1'b1;
    for (int k = 0; k < 34; k++) begin
      @(negedge clk);
      start = 1'b0;
      btr[k] = busy;
      dtr[k] = done;
    end
    check("multu busy trace", btr, 34'h1_FFFF_FFFF);
    check("multu done trace", dtr, 34'h2_0000_0000);
    run(OP_MULT, 32'hFFFFFFF9, 32'd3, 1, 0, mk(32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0));

`ifdef MULDIV_DIV_EN
    run(OP_DIV, 32'hFFFFFFF9, 32'd2, 1, 0, mk(32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0));
    run(OP_DIVU, 32'd100, 32'd0, 1, 1, mk(32'd100, 32'hFFFFFFFF, 1'b1));
    check("div_zero sticky", dz, 1);
    run(OP_MTLO, 32'd5, 32'd0, 1, 1, mk(32'd100, 32'd5, 1'b0));
    run(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1, 0, mk(32'h0, 32'h80000000, 1'b0));
    run(OP_DIVU, 32'd1000, 32'd7, 1, 0, mk(32'd6, 32'd142, 1'b0));
    run(OP_DIV, 32'd7, 32'hFFFFFFFE, 1, 0, mk(32'd1, 32'hFFFFFFFD, 1'b0));
`else
    run(OP_DIV, 32'd100, 32'd3, 0, 0, mk(32'h0, 32'h0, 1'b0));
    run(OP_DIVU, 32'd100, 32'd0, 0, 0, mk(32'h0, 32'h0, 1'b0));
    check("no-div div_zero", dz, 0);
    check("no-div hi kept", hi, hi_m);
    check("no-div lo kept", lo, lo_m);
`endif

    run(OP_MULT, 32'h80000000, 32'h80000000, 1, 0, mk(32'h40000000, 32'h0, 1'b0));
    run(OP_MULTU, 32'h12345678, 32'h10, 1, 0, mk(32'h1, 32'h23456780, 1'b0));
    run(OP_MTHI, 32'hDEADBEEF, 32'd0, 1, 1, mk(32'hDEADBEEF, lo_m, 1'b0));

    run(3'b110, 32'h1234, 32'h5678, 0, 0, mk(32'h0, 32'h0, 1'b0));
    check("invalid op hi kept", hi, hi_m);
    check("invalid op lo kept", lo, lo_m);

    // Flush mid-multiply, with a start pulsed while busy.
    op = OP_MULT; a = 32'd5; b = 32'd5; start = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      start = (k == 4);
      if (k == 4) begin
        op = OP_MTHI;
        a  = 32'h1111;
      end
      flush = (k == 10);
      if (k == 9) check("busy before flush", busy, 1);
      if (k == 11) check("idle after flush", busy, 0);
    end
    repeat (40) @(negedge clk);
    check("flush hi kept", hi, hi_m);
    check("flush lo kept", lo, lo_m);

    op = OP_MTLO; a = 32'h77; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    repeat (3) @(negedge clk);
    check("flush+start lo kept", lo, lo_m);

    // DATA_W=8: latency DATA_W+1.
    q8.push_back(mk(32'hFE, 32'h01, 1'b0));
    op8 = OP_MULTU; a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      start8 = 1'b0;
      btr8[k] = busy8;
      dtr8[k] = done8;
    end
    check("multu8 busy trace", btr8, 10'h1FF);
    check("multu8 done trace", dtr8, 10'h200);
`ifdef MULDIV_DIV_EN
    run8(OP_DIV, 8'h80, 8'hFF, mk(32'h00, 32'h80, 1'b0));
`else
    run8(OP_MULT, 8'h80, 8'hFF, mk(32'h00, 32'h80, 1'b0));
`endif

    // Asynchronous reset in the middle of an operation.
`ifdef MULDIV_DIV_EN
    op = OP_DIV;
`else
    op = OP_MULT;
`endif
    a = 32'd1000; b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("async reset busy", busy, 0);
    check("async reset done", done, 0);
    check("async reset hi", hi, 0);
    check("async reset lo", lo, 0);
    check("async reset div_zero", dz, 0);
    check("async reset lo8", lo8, 0);
    @(negedge clk);
    rst = 1'b0;
    hi_m = '0;
    lo_m = '0;
    @(negedge clk);
    run(OP_MULTU, 32'd3, 32'd4, 1, 0, mk(32'h0, 32'd12, 1'b0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
